pipe_ctrl: RTL and testbench

- Pipeline sequencer for the RV32IM core's IF, IF_ID, ID and ID_EX stages.
- Detects load-use hazards between ID and EX and inserts one bubble.
- Runs the hold/handshake protocol for the multi-cycle MUL/DIV unit.
- Converts EX-stage jump/branch-taken requests into PC redirect plus stage flushes.
- Single controller; all stall/flush/jump outputs go to pc_reg, if_id and id_ex.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_hazard_detect.sv | 25 ++
 rtl/pipe_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings and
// the codebase-wide zero/enable constants.
package pipe_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned STATE_W  = 2;

    // FSM state encodings (legacy names kept for the rest of the core)
    localparam logic [STATE_W-1:0] PC_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] PC_DIV_START = 2'd1;
    localparam logic [STATE_W-1:0] PC_DIV_BUSY  = 2'd2;
    localparam logic [STATE_W-1:0] PC_FLUSH     = 2'd3;

    localparam logic [XLEN-1:0]   ZeroWord    = 32'h0000_0000;
    localparam logic [REG_AW-1:0] ZeroReg     = 5'd0;
    localparam logic              WriteEnable = 1'b1;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the operands read in ID.
// Ports:
//   id_raddr1_i/id_raddr2_i : ID source register addresses
//   ex_reg_we_i, ex_reg_waddr_i, ex_is_load_i : EX destination info
//   load_use_c : combinational hazard flag
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] id_raddr1_i,
    input  logic [REG_AW-1:0] id_raddr2_i,
    input  logic              ex_reg_we_i,
    input  logic [REG_AW-1:0] ex_reg_waddr_i,
    input  logic              ex_is_load_i,
    output logic              load_use_c
);

    // x0 never carries a dependency, so a load targeting it cannot stall
    always_comb begin
        load_use_c = ex_is_load_i
                  && (ex_reg_we_i == WriteEnable)
                  && (ex_reg_waddr_i != ZeroReg)
                  && ((ex_reg_waddr_i == id_raddr1_i) || (ex_reg_waddr_i == id_raddr2_i));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for IF, IF_ID, ID and ID_EX: load-use bubble insertion,
// MUL/DIV hold/start handshake with timeout, and jump redirect plus flushes.
// Ports:
//   clk, rst_n           : clock, synchronous active-high reset (1 = reset)
//   id_raddr1_i/2_i      : ID operand addresses
//   ex_reg_we_i, ex_reg_waddr_i, ex_is_load_i : EX writeback info
//   ex_jump_i, ex_jump_addr_i : EX redirect request and target
//   ex_div_req_i, div_done_i  : muldiv request from EX / completion pulse
//   hold_*_o, flush_*_o  : stage freeze / NOP-load controls
//   jump_flag_o, jump_addr_o  : PC redirect
//   div_start_o          : one-cycle muldiv start
//   div_err_o            : sticky muldiv timeout (registered)
//   state_o              : FSM state for debug
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = 64,
    parameter int unsigned FLUSH_EXTRA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_raddr1_i,
    input  logic [REG_AW-1:0] id_raddr2_i,
    input  logic              ex_reg_we_i,
    input  logic [REG_AW-1:0] ex_reg_waddr_i,
    input  logic              ex_is_load_i,
    input  logic              ex_jump_i,
    input  logic [XLEN-1:0]   ex_jump_addr_i,
    input  logic              ex_div_req_i,
    input  logic              div_done_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              jump_flag_o,
    output logic [XLEN-1:0]   jump_addr_o,
    output logic              div_start_o,
    output logic              div_err_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned DIV_CNT_W   = $clog2(DIV_TIMEOUT + 1);
    localparam int unsigned FLUSH_CNT_W = 2;

    localparam logic [DIV_CNT_W-1:0]   DivCntMax = DIV_CNT_W'(DIV_TIMEOUT);
    localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FLUSH_EXTRA);
    localparam bit                     FlushEn   = (FLUSH_EXTRA > 0);

    logic [STATE_W-1:0]     state, state_nxt;
    logic [DIV_CNT_W-1:0]   div_cnt, div_cnt_nxt;
    logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
    logic                   div_err_nxt;
    logic                   load_use_c;

    pipe_ctrl_hazard_detect u_hazard_detect (
        .id_raddr1_i    (id_raddr1_i),
        .id_raddr2_i    (id_raddr2_i),
        .ex_reg_we_i    (ex_reg_we_i),
        .ex_reg_waddr_i (ex_reg_waddr_i),
        .ex_is_load_i   (ex_is_load_i),
        .load_use_c     (load_use_c)
    );

    assign state_o = state;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= PC_IDLE;
            div_cnt   <= '0;
            flush_cnt <= '0;
            div_err_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
            div_err_o <= div_err_nxt;
        end
    end

    // Next-state and combinational stage controls
    always_comb begin
        state_nxt     = state;
        div_cnt_nxt   = div_cnt;
        flush_cnt_nxt = flush_cnt;
        div_err_nxt   = div_err_o;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        jump_flag_o   = 1'b0;
        jump_addr_o   = ZeroWord;
        div_start_o   = 1'b0;

        case (state)
            PC_IDLE: begin
                // div beats jump beats load-use; div+jump together drops the jump
                if (ex_div_req_i) begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    state_nxt    = PC_DIV_START;
                end else if (ex_jump_i) begin
                    jump_flag_o   = 1'b1;
                    jump_addr_o   = ex_jump_addr_i;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (FlushEn) begin
                        state_nxt     = PC_FLUSH;
                        flush_cnt_nxt = FlushLoad;
                    end
                end else if (load_use_c) begin
                    // bubble into EX; the bubble clears the hazard next cycle
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
            end

            PC_DIV_START: begin
                hold_pc_o    = 1'b1;
                hold_if_id_o = 1'b1;
                hold_id_ex_o = 1'b1;
                div_start_o  = 1'b1;
                div_cnt_nxt  = '0;
                state_nxt    = PC_DIV_BUSY;
            end

            PC_DIV_BUSY: begin
                if (div_done_i) begin
                    // result lands this cycle, so release the pipe immediately
                    state_nxt = PC_IDLE;
                end else begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    if (div_cnt != DivCntMax) begin
                        div_cnt_nxt = div_cnt + DIV_CNT_W'(1);
                    end
                    if (div_cnt_nxt == DivCntMax) begin
                        div_err_nxt = 1'b1;
                    end
                end
            end

            PC_FLUSH: begin
                // IF_ID keeps loading NOPs while the instruction ROM catches up
                flush_if_id_o = 1'b1;
                if (ex_jump_i) begin
                    jump_flag_o   = 1'b1;
                    jump_addr_o   = ex_jump_addr_i;
                    flush_id_ex_o = 1'b1;
                    flush_cnt_nxt = FlushLoad;
                end else if (flush_cnt <= FLUSH_CNT_W'(1)) begin
                    state_nxt     = PC_IDLE;
                    flush_cnt_nxt = '0;
                end else begin
                    flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
                end
            end

            default: begin
                state_nxt = PC_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the sequencer.
module tb_pipe_ctrl;

    localparam int unsigned TB_DIV_TIMEOUT = 64;
    localparam int unsigned TB_FLUSH_EXTRA = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_raddr1, id_raddr2, ex_reg_waddr;
    logic        ex_reg_we, ex_is_load, ex_jump, ex_div_req, div_done;
    logic [31:0] ex_jump_addr;
    logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;
    logic        jump_flag, div_start, div_err;
    logic [31:0] jump_addr;
    logic [1:0]  state;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .DIV_TIMEOUT (TB_DIV_TIMEOUT),
        .FLUSH_EXTRA (TB_FLUSH_EXTRA)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_raddr1_i    (id_raddr1),
        .id_raddr2_i    (id_raddr2),
        .ex_reg_we_i    (ex_reg_we),
        .ex_reg_waddr_i (ex_reg_waddr),
        .ex_is_load_i   (ex_is_load),
        .ex_jump_i      (ex_jump),
        .ex_jump_addr_i (ex_jump_addr),
        .ex_div_req_i   (ex_div_req),
        .div_done_i     (div_done),
        .hold_pc_o      (hold_pc),
        .hold_if_id_o   (hold_if_id),
        .hold_id_ex_o   (hold_id_ex),
        .flush_if_id_o  (flush_if_id),
        .flush_id_ex_o  (flush_id_ex),
        .jump_flag_o    (jump_flag),
        .jump_addr_o    (jump_addr),
        .div_start_o    (div_start),
        .div_err_o      (div_err),
        .state_o        (state)
    );

    int checks = 0;
    int passes = 0;

    // Model: which phase the controller is in, cycles left in the post-jump
    // flush window, DIV_BUSY cycles elapsed without a result, sticky error.
    int m_phase;       // 0 idle, 1 starting div, 2 waiting on div, 3 flushing
    int m_flush_left;
    int m_busy;
    bit m_err;

    // Output bundle: {hold_pc, hold_if_id, hold_id_ex, flush_if_id,
    //                 flush_id_ex, jump_flag, div_start, div_err, state[1:0]}
    function automatic logic [9:0] model_out(output logic [31:0] addr);
        bit lu, hp, hi, he, fi, fe, jf, ds;
        lu = ex_is_load && ex_reg_we && (ex_reg_waddr != 5'd0)
          && (ex_reg_waddr == id_raddr1 || ex_reg_waddr == id_raddr2);
        {hp, hi, he, fi, fe, jf, ds} = '0;
        addr = 32'h0;
        if (m_phase == 0) begin
            if (ex_div_req)      begin hp = 1; hi = 1; he = 1; end
            else if (ex_jump)    begin jf = 1; addr = ex_jump_addr; fi = 1; fe = 1; end
            else if (lu)         begin hp = 1; hi = 1; fe = 1; end
        end else if (m_phase == 1) begin
            hp = 1; hi = 1; he = 1; ds = 1;
        end else if (m_phase == 2) begin
            if (!div_done) begin hp = 1; hi = 1; he = 1; end
        end else begin
            fi = 1;
            if (ex_jump) begin jf = 1; addr = ex_jump_addr; fe = 1; end
        end
        return {hp, hi, he, fi, fe, jf, ds, m_err, 2'(m_phase)};
    endfunction

    task automatic model_step();
        if (rst_n) begin
            m_phase = 0; m_flush_left = 0; m_busy = 0; m_err = 0;
        end else if (m_phase == 0) begin
            if (ex_div_req) m_phase = 1;
            else if (ex_jump && TB_FLUSH_EXTRA > 0) begin
                m_phase = 3; m_flush_left = TB_FLUSH_EXTRA;
            end
        end else if (m_phase == 1) begin
            m_phase = 2; m_busy = 0;
        end else if (m_phase == 2) begin
            if (div_done) m_phase = 0;
            else begin
                if (m_busy < TB_DIV_TIMEOUT) m_busy++;
                if (m_busy == TB_DIV_TIMEOUT) m_err = 1;
            end
        end else begin
            if (ex_jump) m_flush_left = TB_FLUSH_EXTRA;
            else begin
                m_flush_left--;
                if (m_flush_left <= 0) begin m_phase = 0; m_flush_left = 0; end
            end
        end
    endtask

    task automatic compare(input string name, input logic [9:0] exp, input logic [31:0] exp_addr);
        logic [9:0] act;
        act = {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex,
               jump_flag, div_start, div_err, state};
        checks++;
        if (act === exp && jump_addr === exp_addr) passes++;
        else $display("FAIL %s: got ctl=%b addr=%h, want ctl=%b addr=%h",
                      name, act, jump_addr, exp, exp_addr);
    endtask

    // One clock: sample at negedge against the model (and an optional literal),
    // advance the model, then return just after the next rising edge.
    task automatic tick(input string name, input bit pin,
                        input logic [9:0] pin_ctl, input logic [31:0] pin_addr);
        logic [9:0]  e;
        logic [31:0] ea;
        @(negedge clk);
        e = model_out(ea);
        compare(name, e, ea);
        if (pin) compare({name, "_lit"}, pin_ctl, pin_addr);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rst_n = 0; id_raddr1 = 0; id_raddr2 = 0; ex_reg_we = 0; ex_reg_waddr = 0;
        ex_is_load = 0; ex_jump = 0; ex_jump_addr = 0; ex_div_req = 0; div_done = 0;
    endtask

    initial begin
        clr_in();
        rst_n = 1;
        m_phase = 0; m_flush_left = 0; m_busy = 0; m_err = 0;
        @(posedge clk); #1;
        tick("reset_hold", 0, '0, '0);
        rst_n = 0;
        tick("after_reset", 1, 10'b0000000000, 32'h0);

        // Load-use on rs1, then the bubble cycle, then rd=x0
        ex_is_load = 1; ex_reg_we = 1; ex_reg_waddr = 5'd5; id_raddr1 = 5'd5;
        tick("load_use", 1, 10'b1100100000, 32'h0);
        clr_in();
        tick("load_use_bubble", 1, 10'b0000000000, 32'h0);
        ex_is_load = 1; ex_reg_we = 1; ex_reg_waddr = 5'd0; id_raddr1 = 5'd0;
        tick("load_x0", 1, 10'b0000000000, 32'h0);
        clr_in();

        // Jump with one extra flush cycle
        ex_jump = 1; ex_jump_addr = 32'h0000_0100;
        tick("jump_c0", 1, 10'b0001110000, 32'h0000_0100);
        clr_in();
        tick("jump_c1", 1, 10'b0001000011, 32'h0);
        tick("jump_c2", 1, 10'b0000000000, 32'h0);

        // Div with result on the 34th busy cycle
        ex_div_req = 1;
        tick("div_req", 1, 10'b1110000000, 32'h0);
        tick("div_start", 1, 10'b1110001001, 32'h0);
        for (int i = 1; i <= 33; i++) tick("div_busy", 1, 10'b1110000010, 32'h0);
        div_done = 1;
        tick("div_done", 1, 10'b0000000010, 32'h0);
        clr_in();
        tick("div_after", 1, 10'b0000000000, 32'h0);
        div_done = 1;
        tick("done_in_idle", 1, 10'b0000000000, 32'h0);
        clr_in();

        // All three requests at once: div wins, no redirect
        ex_div_req = 1; ex_jump = 1; ex_jump_addr = 32'hDEAD_BEE0;
        ex_is_load = 1; ex_reg_we = 1; ex_reg_waddr = 5'd7; id_raddr2 = 5'd7;
        tick("triple", 1, 10'b1110000000, 32'h0);
        clr_in();
        tick("triple_start", 1, 10'b1110001001, 32'h0);
        div_done = 1;
        tick("triple_done", 1, 10'b0000000010, 32'h0);
        clr_in();

        // Jump and load-use together: redirect, no hold
        ex_jump = 1; ex_jump_addr = 32'h0000_2000;
        ex_is_load = 1; ex_reg_we = 1; ex_reg_waddr = 5'd3; id_raddr1 = 5'd3;
        tick("jump_lu", 1, 10'b0001110000, 32'h0000_2000);
        clr_in();
        tick("jump_lu_flush", 1, 10'b0001000011, 32'h0);

        // Reset in the middle of DIV_BUSY abandons the op
        ex_div_req = 1;
        tick("rst_div_req", 0, '0, '0);
        tick("rst_div_start", 0, '0, '0);
        tick("rst_div_busy", 1, 10'b1110000010, 32'h0);
        rst_n = 1;
        tick("rst_pulse", 0, '0, '0);
        clr_in();
        for (int i = 0; i < 3; i++) tick("post_rst", 1, 10'b0000000000, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 199) == 0);
            id_raddr1    = 5'($urandom_range(0, 7));
            id_raddr2    = 5'($urandom_range(0, 7));
            ex_reg_waddr = 5'($urandom_range(0, 7));
            ex_reg_we    = ($urandom_range(0, 3) != 0);
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_jump      = ($urandom_range(0, 5) == 0);
            ex_jump_addr = $urandom();
            ex_div_req   = ($urandom_range(0, 7) == 0);
            div_done     = ($urandom_range(0, 15) == 0);
            if (m_phase == 3) begin
                // EX holds a flushed NOP during the flush window
                ex_jump = 0; ex_div_req = 0; ex_is_load = 0;
            end
            tick("random", 0, '0, '0);
        end

        // Timeout: no result for DIV_TIMEOUT busy cycles
        clr_in();
        rst_n = 1;
        tick("to_reset", 0, '0, '0);
        rst_n = 0;
        ex_div_req = 1;
        tick("to_req", 1, 10'b1110000000, 32'h0);
        tick("to_start", 1, 10'b1110001001, 32'h0);
        for (int i = 1; i <= 64; i++) tick("to_busy", 1, 10'b1110000010, 32'h0);
        tick("to_err", 1, 10'b1110000110, 32'h0);
        div_done = 1;
        tick("to_late_done", 1, 10'b0000000110, 32'h0);
        clr_in();
        tick("to_sticky", 1, 10'b0000000100, 32'h0);
        rst_n = 1;
        tick("to_rst", 0, '0, '0);
        rst_n = 0;
        tick("to_cleared", 1, 10'b0000000000, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
